// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//
// Match sequencer for the Pong datapath. It owns the match state machine
// (idle, serve delay, rally, game over), keeps both players' scores for the
// 7-segment digits, gates paddle/ball motion and requests a ball re-serve.
//
// Parameters
//   SCORE_LIMIT   points needed to win (1..15)
//   SERVE_FRAMES  frame ticks spent in SERVE before the ball is launched (1..255)
//   BLINK_FRAMES  frame ticks per half-period of o_Blink in GAME_OVER (1..255)
//
// Ports
//   i_Clk          system clock
//   i_Rst_L        asynchronous active-low reset
//   i_VSync        VGA vertical sync; a frame tick is its registered 1->0 edge
//   i_Game_Start   debounced start level; only the rising edge acts
//   i_P1_Miss      1-cycle pulse, ball passed player 1 paddle
//   i_P2_Miss      1-cycle pulse, ball passed player 2 paddle
//   o_Game_Active  high only in PLAY; enables ball and paddle motion
//   o_Serve        1-cycle pulse: re-centre and launch the ball
//   o_P1_Score     player 1 score, binary
//   o_P2_Score     player 2 score, binary
//   o_Winner       00 none, 01 player 1, 10 player 2
//   o_Blink        toggles every BLINK_FRAMES ticks in GAME_OVER, 0 elsewhere
//   o_State        00 IDLE, 01 SERVE, 10 PLAY, 11 GAME_OVER
//
// All outputs are registered: an event sampled on edge N is visible after N.
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int unsigned SCORE_LIMIT  = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_VSync,
  input  logic       i_Game_Start,
  input  logic       i_P1_Miss,
  input  logic       i_P2_Miss,
  output logic       o_Game_Active,
  output logic       o_Serve,
  output logic [3:0] o_P1_Score,
  output logic [3:0] o_P2_Score,
  output logic [1:0] o_Winner,
  output logic       o_Blink,
  output logic [1:0] o_State
);

  // State encoding is exported unchanged on o_State.
  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StServe    = 2'b01,
    StPlay     = 2'b10,
    StGameOver = 2'b11
  } state_e;

  localparam logic [3:0] ScoreLimit  = 4'(SCORE_LIMIT);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);
  localparam logic [7:0] BlinkFrames = 8'(BLINK_FRAMES);

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic [7:0] frame_cnt_q;
  logic [3:0] p1_score_q;
  logic [3:0] p2_score_q;
  logic [1:0] winner_q;
  logic       game_active_q;
  logic       serve_q;
  logic       blink_q;
  logic       vsync_q;
  logic       start_q;

  // ---------------------------------------------------------------------------
  // Edge strobes and helper arithmetic
  // ---------------------------------------------------------------------------
  logic       frame_tick;
  logic       start_edge;
  logic [7:0] frame_cnt_inc;
  logic [3:0] p1_score_inc;
  logic [3:0] p2_score_inc;

  // Frame tick on the falling edge of VSync, start on the rising edge of the
  // start level. Each is high for exactly one clock.
  assign frame_tick = vsync_q & ~i_VSync;
  assign start_edge = ~start_q & i_Game_Start;

  assign frame_cnt_inc = frame_cnt_q + 8'd1;

  // Saturating increments so a score can never run past the limit or wrap.
  always_comb begin
    p1_score_inc = p1_score_q;
    p2_score_inc = p2_score_q;
    if (p1_score_q < ScoreLimit) begin
      p1_score_inc = p1_score_q + 4'd1;
    end
    if (p2_score_q < ScoreLimit) begin
      p2_score_inc = p2_score_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Input edge-detect registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vsync_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      vsync_q <= i_VSync;
      start_q <= i_Game_Start;
    end
  end

  // ---------------------------------------------------------------------------
  // Match state machine with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= StIdle;
      frame_cnt_q   <= 8'd0;
      p1_score_q    <= 4'd0;
      p2_score_q    <= 4'd0;
      winner_q      <= WinNone;
      game_active_q <= 1'b0;
      serve_q       <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      // o_Serve is a single-cycle pulse unless re-asserted below.
      serve_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            winner_q    <= WinNone;
            frame_cnt_q <= 8'd0;
            state_q     <= StServe;
          end
        end

        StServe: begin
          // Start and misses are ignored here; the start switch shares a pin
          // with a paddle input.
          if (frame_tick) begin
            if (frame_cnt_inc == ServeFrames) begin
              serve_q       <= 1'b1;
              game_active_q <= 1'b1;
              frame_cnt_q   <= 8'd0;
              state_q       <= StPlay;
            end else begin
              frame_cnt_q <= frame_cnt_inc;
            end
          end
        end

        StPlay: begin
          // Frame ticks are irrelevant during a rally; a miss always wins.
          if (i_P1_Miss && i_P2_Miss) begin
            // Simultaneous miss: no point, just re-serve.
            game_active_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            state_q       <= StServe;
          end else if (i_P1_Miss) begin
            game_active_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            p2_score_q    <= p2_score_inc;
            if (p2_score_inc == ScoreLimit) begin
              winner_q <= WinP2;
              state_q  <= StGameOver;
            end else begin
              state_q <= StServe;
            end
          end else if (i_P2_Miss) begin
            game_active_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            p1_score_q    <= p1_score_inc;
            if (p1_score_inc == ScoreLimit) begin
              winner_q <= WinP1;
              state_q  <= StGameOver;
            end else begin
              state_q <= StServe;
            end
          end
        end

        StGameOver: begin
          // Start beats a coincident tick so the new serve delay starts at 0.
          if (start_edge) begin
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            winner_q    <= WinNone;
            blink_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            state_q     <= StServe;
          end else if (frame_tick) begin
            if (frame_cnt_inc == BlinkFrames) begin
              blink_q     <= ~blink_q;
              frame_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_cnt_inc;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (straight from registers)
  // ---------------------------------------------------------------------------
  assign o_Game_Active = game_active_q;
  assign o_Serve       = serve_q;
  assign o_P1_Score    = p1_score_q;
  assign o_P2_Score    = p2_score_q;
  assign o_Winner      = winner_q;
  assign o_Blink       = blink_q;
  assign o_State       = state_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the Pong datapath. It owns the match state machine: start, serve delay, rally, point award and game over. It counts per-player scores for the two 7-segment digits and gates the Pong block's play enable and ball re-serve. It sits between the debounced switches / Pong miss events and the Pong and BinaryTo7Segment instances.

Parameters:
SCORE_LIMIT, 9, points needed to win; legal range 1..15.
SERVE_FRAMES, 60, frame ticks spent in SERVE before the ball is released; legal range 1..255.
BLINK_FRAMES, 30, frame ticks per half-period of o_Blink in GAME_OVER; legal range 1..255.

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  reset, asynchronous, active-low
i_VSync  in  1  VGA vertical sync from VGA_Sync_Pulses; frame tick = registered 1->0 transition
i_Game_Start  in  1  debounced start level; only its rising edge acts
i_P1_Miss  in  1  1-cycle pulse: ball passed player 1 paddle
i_P2_Miss  in  1  1-cycle pulse: ball passed player 2 paddle
o_Game_Active  out  1  high only in PLAY; enables ball and paddle motion
o_Serve  out  1  1-cycle pulse: re-centre and launch the ball
o_P1_Score  out  4  player 1 score, binary 0..SCORE_LIMIT
o_P2_Score  out  4  player 2 score, binary 0..SCORE_LIMIT
o_Winner  out  2  00 none, 01 P1, 10 P2
o_Blink  out  1  toggles in GAME_OVER; 0 elsewhere
o_State  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 GAME_OVER

Behaviour:
- Reset (i_Rst_L low, async): state IDLE; scores 0; o_Game_Active 0; o_Serve 0; o_Winner 00; o_Blink 0; frame counter 0; edge-detect registers 0. Reset asserted mid-game aborts immediately. No serve pulse on release.
- Edge detect: one register each on i_VSync and i_Game_Start. tick = prev & ~cur; start = ~prev & cur. Both are single-cycle internal strobes.
- All outputs are registered. An event sampled at cycle N is visible at cycle N+1.
- IDLE: on start, clear scores, clear o_Winner, frame counter to 0, go to SERVE.
- SERVE: each tick increments the frame counter. On the tick that makes the count equal SERVE_FRAMES: pulse o_Serve for 1 cycle, go to PLAY, counter to 0. o_Game_Active rises in the same cycle as o_Serve.
- PLAY:
  - i_P1_Miss alone: o_P2_Score +1.
  - i_P2_Miss alone: o_P1_Score +1.
  - Both misses in the same cycle: no score change; go to SERVE.
  - After a single-miss point: if the new score equals SCORE_LIMIT, go to GAME_OVER and set o_Winner to the scorer. Otherwise go to SERVE with counter 0.
  - o_Game_Active drops in the cycle after the miss.
- GAME_OVER: scores and o_Winner are held. Each tick increments the counter. When the count reaches BLINK_FRAMES, toggle o_Blink and reset the counter to 0. On start: clear scores, o_Winner, o_Blink and counter, then go to SERVE.
- Ignored inputs:
  - Misses in IDLE, SERVE and GAME_OVER.
  - Start in SERVE and PLAY. This is required because the start switch shares a pin with the P2 paddle-down input.
- Priority: start and tick in the same cycle in IDLE or GAME_OVER means start wins and the counter is 0 after the transition. A miss and a tick in the same cycle in PLAY means the miss is processed and the tick is discarded.
- Scores never exceed SCORE_LIMIT and never wrap. The counter is 8 bits.
- o_State encodes the current state register directly.

Test Plan:
1. Reset: hold i_Rst_L low for 5 cycles, then release with inputs idle. Expect state 00, scores 0/0, o_Winner 00, o_Game_Active 0, and no o_Serve for 1000 cycles.
2. Serve (SERVE_FRAMES=4): raise i_Game_Start, then generate 4 VSync falls. Expect o_State=01 until the cycle after the 4th fall, then a single o_Serve pulse with o_Game_Active=1 and o_State=10.
3. Scoring: in PLAY, pulse i_P1_Miss. Expect o_P2_Score=1, o_P1_Score=0 and o_State=01 the next cycle. Re-serve, then pulse i_P1_Miss and i_P2_Miss together: scores unchanged, o_State=01.
4. Win (SCORE_LIMIT=3, BLINK_FRAMES=2): player 1 scores 3 points. Expect o_State=11, o_Winner=01, o_P1_Score=3, and o_Blink toggling every 2 ticks. Extra i_P2_Miss pulses leave the scores unchanged.
5. Ignored start: toggle i_Game_Start during SERVE and during PLAY. There is no state or score change. In GAME_OVER a start edge gives scores 0/0, o_Winner 00, o_Blink 0 and o_State=01.
6. Async reset mid-rally: at score 2-1 in PLAY, drop i_Rst_L between clock edges. Outputs go to reset values before the next edge, and no o_Serve follows release.
